// File: rtl/forward_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// forward_pkg : shared operand-select encoding for the forwarding unit
// Revision    : 1.0
// ---------------------------------------------------------------------------
package forward_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_EX  = 2'b10
   } fwd_sel_t;

   localparam int REG_ZERO = 0;

   // Number of operands (0..2) selecting a given source this cycle.
   function automatic logic [1:0] fwd_count(input fwd_sel_t a, input fwd_sel_t b,
                                            input fwd_sel_t which);
      fwd_count = {1'b0, a == which} + {1'b0, b == which};
   endfunction

endpackage
`default_nettype wire

// File: rtl/forward_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// forward_sel : picks the operand source for one EX-stage source register
// Revision    : 1.0
// ---------------------------------------------------------------------------
module forward_sel
   import forward_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             ex_mem_regwrite,
   input  logic             mem_wb_regwrite,
   input  logic [REG_W-1:0] ex_mem_rwr,
   input  logic [REG_W-1:0] mem_wb_rwr,
   input  logic [REG_W-1:0] src,
   output fwd_sel_t         sel
);

   logic hit_ex;
   logic hit_mem;

   // r0 is hardwired to zero, so a write to it never produces a value to forward.
   assign hit_ex  = ex_mem_regwrite && (ex_mem_rwr != REG_W'(REG_ZERO)) && (ex_mem_rwr == src);
   assign hit_mem = mem_wb_regwrite && (mem_wb_rwr != REG_W'(REG_ZERO)) && (mem_wb_rwr == src);

   always_comb begin
      sel = FWD_RF;
      if (hit_ex) begin
         sel = FWD_EX;
      end else if (hit_mem) begin
         sel = FWD_MEM;
      end
   end

endmodule
`default_nettype wire

// File: rtl/forward_u.sv
`default_nettype none
// ---------------------------------------------------------------------------
// forward_u : EX-stage forwarding decision with trace stage; event counters
//             are built when FORWARDU_STATS_EN is defined.
// Revision  : 1.0
// ---------------------------------------------------------------------------
module forward_u
   import forward_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             EX_MEM__RegWrite,
   input  logic             MEM_WB__RegWrite,
   input  logic [REG_W-1:0] EX_MEM__rWR,
   input  logic [REG_W-1:0] MEM_WB__rWR,
   input  logic [REG_W-1:0] ID_EX__rs,
   input  logic [REG_W-1:0] ID_EX__rt,
   output logic [1:0]       ForwA,
   output logic [1:0]       ForwB,
   output logic [1:0]       ForwA_q,
   output logic [1:0]       ForwB_q
`ifdef FORWARDU_STATS_EN
   ,
   output logic [CNT_W-1:0] fwd_ex_cnt,
   output logic [CNT_W-1:0] fwd_mem_cnt
`endif
);

   fwd_sel_t sel_a;
   fwd_sel_t sel_b;

   forward_sel #(.REG_W(REG_W)) u_sel_rs (
      .ex_mem_regwrite (EX_MEM__RegWrite),
      .mem_wb_regwrite (MEM_WB__RegWrite),
      .ex_mem_rwr      (EX_MEM__rWR),
      .mem_wb_rwr      (MEM_WB__rWR),
      .src             (ID_EX__rs),
      .sel             (sel_a)
   );

   forward_sel #(.REG_W(REG_W)) u_sel_rt (
      .ex_mem_regwrite (EX_MEM__RegWrite),
      .mem_wb_regwrite (MEM_WB__RegWrite),
      .ex_mem_rwr      (EX_MEM__rWR),
      .mem_wb_rwr      (MEM_WB__rWR),
      .src             (ID_EX__rt),
      .sel             (sel_b)
   );

   assign ForwA = sel_a;
   assign ForwB = sel_b;

   logic [1:0] fwd_a_d, fwd_a_q;
   logic [1:0] fwd_b_d, fwd_b_q;

   always_comb begin
      fwd_a_d = sel_a;
      fwd_b_d = sel_b;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
      end else begin
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign ForwA_q = fwd_a_q;
   assign ForwB_q = fwd_b_q;

`ifdef FORWARDU_STATS_EN
   localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

   logic [CNT_W-1:0] ex_cnt_d,  ex_cnt_q;
   logic [CNT_W-1:0] mem_cnt_d, mem_cnt_q;
   logic [CNT_W+1:0] ex_sum;
   logic [CNT_W+1:0] mem_sum;

   // Two spare bits keep the +2 step from wrapping even for tiny CNT_W.
   always_comb begin
      ex_sum    = {2'b00, ex_cnt_q}  + (CNT_W+2)'(fwd_count(sel_a, sel_b, FWD_EX));
      mem_sum   = {2'b00, mem_cnt_q} + (CNT_W+2)'(fwd_count(sel_a, sel_b, FWD_MEM));
      ex_cnt_d  = (ex_sum  > CNT_MAX) ? {CNT_W{1'b1}} : ex_sum[CNT_W-1:0];
      mem_cnt_d = (mem_sum > CNT_MAX) ? {CNT_W{1'b1}} : mem_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_cnt_q  <= '0;
         mem_cnt_q <= '0;
      end else begin
         ex_cnt_q  <= ex_cnt_d;
         mem_cnt_q <= mem_cnt_d;
      end
   end

   assign fwd_ex_cnt  = ex_cnt_q;
   assign fwd_mem_cnt = mem_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_forward_u.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_forward_u : scoreboard bench for forward_u (directed + random vectors)
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_forward_u;

   localparam int REG_W = 5;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             we_ex = 1'b0, we_mem = 1'b0;
   logic [REG_W-1:0] d_ex = '0, d_mem = '0, rs = '0, rt = '0;
   logic [1:0]       forw_a, forw_b, forw_a_q, forw_b_q;
`ifdef FORWARDU_STATS_EN
   logic [CNT_W-1:0] ex_cnt, mem_cnt;
`endif

   forward_u #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .EX_MEM__RegWrite (we_ex),
      .MEM_WB__RegWrite (we_mem),
      .EX_MEM__rWR      (d_ex),
      .MEM_WB__rWR      (d_mem),
      .ID_EX__rs        (rs),
      .ID_EX__rt        (rt),
      .ForwA            (forw_a),
      .ForwB            (forw_b),
      .ForwA_q          (forw_a_q),
      .ForwB_q          (forw_b_q)
`ifdef FORWARDU_STATS_EN
      ,
      .fwd_ex_cnt       (ex_cnt),
      .fwd_mem_cnt      (mem_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int a, b, qa, qb, ex, mem;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   bit   drv_done = 1'b0;

   // Reference: walk producers newest-first; the first live writer of the source wins.
   function automatic int ref_sel(bit wex, bit wmem, int dex, int dmem, int src);
      int dest[2];
      bit live[2];
      int code[2];
      dest = '{dex, dmem};
      live = '{wex, wmem};
      code = '{2, 1};
      for (int k = 0; k < 2; k++)
         if (live[k] && dest[k] != 0 && dest[k] == src) return code[k];
      return 0;
   endfunction

   int  prev_a = 0, prev_b = 0;
   bit  prev_rst = 1'b1;
   int  m_ex = 0, m_mem = 0;
   int  cmax = (1 << CNT_W) - 1;

   task automatic drive(bit wex, bit wmem, int dex, int dmem, int s, int t, bit r);
      exp_t e;
      int   a, b;
      @(posedge clk);
      #1;
      we_ex = wex; we_mem = wmem;
      d_ex = REG_W'(dex); d_mem = REG_W'(dmem);
      rs = REG_W'(s); rt = REG_W'(t);
      rst = r;
      a = ref_sel(wex, wmem, dex, dmem, s);
      b = ref_sel(wex, wmem, dex, dmem, t);
      if (r || prev_rst) begin
         e.qa = 0; e.qb = 0; m_ex = 0; m_mem = 0;
      end else begin
         e.qa = prev_a; e.qb = prev_b;
         m_ex  = m_ex  + (prev_a == 2) + (prev_b == 2);
         m_mem = m_mem + (prev_a == 1) + (prev_b == 1);
         if (m_ex > cmax)  m_ex  = cmax;
         if (m_mem > cmax) m_mem = cmax;
      end
      e.a = a; e.b = b; e.ex = m_ex; e.mem = m_mem;
      exp_q.push_back(e);
      prev_a = a; prev_b = b; prev_rst = r;
   endtask

   task automatic chk(string name, int act, int expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
   endtask

   // Monitor: outputs are stable at the falling edge, between driver updates.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ForwA", int'(forw_a), e.a);
            chk("ForwB", int'(forw_b), e.b);
            chk("ForwA_q", int'(forw_a_q), e.qa);
            chk("ForwB_q", int'(forw_b_q), e.qb);
`ifdef FORWARDU_STATS_EN
            chk("fwd_ex_cnt", int'(ex_cnt), e.ex);
            chk("fwd_mem_cnt", int'(mem_cnt), e.mem);
`endif
         end
      end
   end

   initial begin
      // reset held, r0 guard
      drive(1, 1, 0, 0, 0, 0, 1);
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 5'b10101, 0, 5'b00001, 0, 0);
      drive(1, 1, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 0);
      drive(1, 1, 5'b00001, 5'b10000, 5'b10000, 5'b10000, 0);
      drive(1, 1, 5'b10001, 5'b10000, 5'b10001, 5'b10000, 0);
      drive(1, 1, 5'b00000, 5'b10000, 5'b10001, 5'b10000, 0);
      drive(0, 0, 5'b00111, 5'b00111, 5'b00111, 5'b00111, 0);
      // EX forwarding held long enough to saturate a 2-bit counter
      drive(1, 0, 3, 0, 3, 3, 1);
      drive(1, 0, 3, 0, 3, 3, 0);
      drive(1, 0, 3, 0, 3, 3, 0);
      drive(1, 0, 3, 0, 3, 3, 0);
      drive(1, 0, 3, 0, 3, 3, 0);
      // mid-run reset with live forwarding
      drive(0, 1, 0, 9, 9, 9, 0);
      drive(0, 1, 0, 9, 9, 9, 1);
      drive(1, 1, 9, 4, 4, 9, 0);
      drive(1, 1, 4, 9, 4, 9, 0);
      // random: small specifier range so matches are frequent
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 39) == 0));
      end
      repeat (3) @(posedge clk);
      drv_done = 1'b1;
   end

   initial begin
      fork
         wait (drv_done && exp_q.size() == 0);
         begin
            #100000;
            $display("FAIL timeout: got %0d pending expected 0", exp_q.size());
            n_total++;
         end
      join_any
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
